// File: rtl/match_report_queue_pkg.sv
// Shared definitions for the match report queue and its bench.
//   NPOS       candidate positions of the 8-bit text / 4-bit pattern matcher
//   POS_W      width of a position index
//   ID_W       frame-id width (wraps modulo 2**ID_W)
//   DEF_FIFO_DEPTH  default number of frames buffered ahead of the walker
//   ST_IDLE / ST_EMIT  walker FSM encodings
package match_report_queue_pkg;

   localparam int TEXT_W         = 8;
   localparam int PAT_W          = 4;
   localparam int NPOS           = TEXT_W - PAT_W + 1;
   localparam int POS_W          = 3;
   localparam int ID_W           = 4;
   localparam int DEF_FIFO_DEPTH = 4;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_EMIT = 1'b1;

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic [NPOS-1:0] hit;
   } frame_t;

   // Index of the highest set bit; 0 for an empty mask.
   function automatic logic [POS_W-1:0] top_pos(input logic [NPOS-1:0] mask);
      logic [POS_W-1:0] p;
      p = '0;
      for (int i = 0; i < NPOS; i++) begin
         if (mask[i]) p = POS_W'(i);
      end
      return p;
   endfunction

   function automatic logic one_hot(input logic [NPOS-1:0] mask);
      return (mask != '0) && ((mask & (mask - NPOS'(1))) == '0);
   endfunction

endpackage

// File: rtl/match_report_queue_hit_fifo.sv
// Synchronous FIFO holding {frame id, hit vector} entries for the walker.
// Read data is the head entry (valid whenever empty is low).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, wdata     write request / data (ignored while full)
//   pop             read request (ignored while empty)
//   rdata           head entry
//   full, empty     occupancy flags from registered pointers
module hit_fifo #(
   parameter int W     = 9,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic         push_ok;
   logic         pop_ok;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rdata   = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
            wr_ptr              <= wr_ptr + (AW+1)'(1);
         end
         if (pop_ok) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

endmodule

// File: rtl/match_report_queue.sv
// Serialises per-frame hit vectors from the pattern matcher into one record
// per hit (highest position first), or a single nomatch record for an empty
// frame, over a valid/ready stream. Counts emitted hits and flags frames whose
// "found" summary disagrees with the hit vector.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no frame loaded; pop the FIFO head as soon as one exists
//   EMIT    | presenting the record for the highest pending bit of pend
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready               hit-vector handshake
//   in_hit[NPOS-1:0], in_found      hit flags per position, matcher summary flag
//   out_valid/out_ready             record handshake
//   out_frame, out_pos              frame id and position of the record
//   out_nomatch, out_last           empty-frame record, final record of frame
//   hit_total                       saturating count of emitted hit records
//   err_found                       sticky found/hit inconsistency flag
module match_report_queue
   import match_report_queue_pkg::*;
#(
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [NPOS-1:0]  in_hit,
   input  logic             in_found,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ID_W-1:0]  out_frame,
   output logic [POS_W-1:0] out_pos,
   output logic             out_nomatch,
   output logic             out_last,
   output logic [15:0]      hit_total,
   output logic             err_found
);

   localparam int FW = ID_W + NPOS;

   logic [0:0]      state;
   logic [NPOS-1:0] pend;
   logic [ID_W-1:0] cur_frame;
   logic [ID_W-1:0] frame_id;

   logic            fifo_full;
   logic            fifo_empty;
   logic            fifo_pop;
   logic [FW-1:0]   fifo_rdata;
   frame_t          head;
   logic            push;
   logic            emitting;
   logic            hs;
   logic            last_rec;
   logic [POS_W-1:0] cur_pos;

   assign in_ready = !fifo_full;
   assign push     = in_valid && !fifo_full;

   hit_fifo #(
      .W     (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata ({frame_id, in_hit}),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign head     = frame_t'(fifo_rdata);
   assign emitting = (state == ST_EMIT);
   assign hs       = emitting && out_ready;
   assign cur_pos  = top_pos(pend);
   // An empty mask is itself the single (nomatch) record of its frame.
   assign last_rec = (pend == '0) || one_hot(pend);

   // Reload straight after the final record so frames stream without a bubble.
   assign fifo_pop = !fifo_empty && ((state == ST_IDLE) || (hs && last_rec));

   assign out_valid   = emitting;
   assign out_frame   = cur_frame;
   assign out_pos     = emitting ? cur_pos : '0;
   assign out_nomatch = emitting && (pend == '0);
   assign out_last    = emitting && last_rec;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         pend      <= '0;
         cur_frame <= '0;
      end else if (fifo_pop) begin
         state     <= ST_EMIT;
         pend      <= head.hit;
         cur_frame <= head.id;
      end else if (hs && last_rec) begin
         state     <= ST_IDLE;
         pend      <= '0;
      end else if (hs) begin
         pend      <= pend & ~(NPOS'(1) << cur_pos);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_id  <= '0;
         err_found <= 1'b0;
      end else if (push) begin
         frame_id <= frame_id + ID_W'(1);
         if (in_found != (|in_hit)) err_found <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_total <= '0;
      end else if (hs && (pend != '0) && (hit_total != 16'hFFFF)) begin
         hit_total <= hit_total + 16'd1;
      end
   end

endmodule

// File: tb/tb_match_report_queue.sv
// Scoreboard bench for match_report_queue: accepted frames are expanded into
// expected records by a reference model; a monitor pops and compares.
module tb_match_report_queue;
   import match_report_queue_pkg::*;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [NPOS-1:0]  in_hit = '0;
   logic             in_found = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [ID_W-1:0]  out_frame;
   logic [POS_W-1:0] out_pos;
   logic             out_nomatch;
   logic             out_last;
   logic [15:0]      hit_total;
   logic             err_found;

   match_report_queue dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_hit     (in_hit),
      .in_found   (in_found),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_frame  (out_frame),
      .out_pos    (out_pos),
      .out_nomatch(out_nomatch),
      .out_last   (out_last),
      .hit_total  (hit_total),
      .err_found  (err_found)
   );

   always #5 clk = ~clk;

   typedef struct {
      int frame;
      int pos;
      bit nomatch;
      bit last;
   } rec_t;

   rec_t exp_q[$];
   int   hs_cycles[$];
   int   compared   = 0;
   int   mismatched = 0;
   int   next_id    = 0;
   int   exp_total  = 0;
   bit   exp_err    = 0;
   bit   monitor_en = 0;
   bit   rand_ready = 0;
   int   cycle      = 0;

   task automatic check(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: one record per set flag, highest position first;
   // a frame without hits yields one nomatch record. Returns the error flag.
   function automatic bit model_accept(input logic [NPOS-1:0] hit, input bit found);
      int n = 0;
      int k = 0;
      for (int p = 0; p < NPOS; p++) if (hit[p]) n++;
      if (n == 0) begin
         exp_q.push_back('{next_id, 0, 1'b1, 1'b1});
      end else begin
         for (int p = NPOS - 1; p >= 0; p--) begin
            if (hit[p]) begin
               k++;
               exp_q.push_back('{next_id, p, 1'b0, k == n});
            end
         end
      end
      next_id = (next_id + 1) % (1 << ID_W);
      return found != (n != 0);
   endfunction

   task automatic send(input logic [NPOS-1:0] hit, input bit found);
      int waited = 0;
      bit bad;
      in_valid = 1'b1;
      in_hit   = hit;
      in_found = found;
      @(negedge clk);
      while (!in_ready && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         check("accept_timeout", 0, 1);
         in_valid = 1'b0;
         return;
      end
      bad = model_accept(hit, found);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (bad) exp_err = 1'b1;
   endtask

   task automatic drain();
      int waited = 0;
      while (exp_q.size() != 0 && waited < 1000) begin
         @(negedge clk);
         waited++;
      end
      if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   always begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
   end

   // Monitor: compares every handshaken record and holds outputs stable
   // across back-pressure.
   rec_t        r;
   bit          stalled = 0;
   logic [10:0] held;

   always @(negedge clk) begin
      cycle++;
      if (!monitor_en) begin
         stalled = 0;
      end else begin
         check("err_found", int'(err_found), int'(exp_err));
         if (stalled)
            check("stable_under_stall", int'({out_valid, out_frame, out_pos, out_nomatch, out_last}),
                  int'(held));
         if (out_valid && out_ready) begin
            check("hit_total", int'(hit_total), exp_total);
            if (exp_q.size() == 0) begin
               check("unexpected_record", 1, 0);
            end else begin
               r = exp_q.pop_front();
               check("out_frame", int'(out_frame), r.frame);
               check("out_pos", int'(out_pos), r.pos);
               check("out_nomatch", int'(out_nomatch), int'(r.nomatch));
               check("out_last", int'(out_last), int'(r.last));
               if (!r.nomatch) exp_total++;
            end
            hs_cycles.push_back(cycle);
         end
         stalled = out_valid && !out_ready;
         held    = {out_valid, out_frame, out_pos, out_nomatch, out_last};
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NPOS-1:0] h;
      bit f;
      int waited;

      // Reset state
      #12;
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_hit_total", int'(hit_total), 0);
      check("rst_err_found", int'(err_found), 0);
      check("rst_out_frame", int'(out_frame), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("in_ready_after_reset", int'(in_ready), 1);
      monitor_en = 1;

      // 1: three hits, descending, with first-record latency
      out_ready = 1'b0;
      send(5'b10101, 1'b1);
      check("latency_not_yet", int'(out_valid), 0);
      @(posedge clk);
      #1;
      check("latency_valid", int'(out_valid), 1);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      drain();
      check("t1_hit_total", int'(hit_total), 3);
      check("t1_err_found", int'(err_found), 0);

      // 2: empty frame gives one nomatch record, count unchanged
      send(5'b00000, 1'b0);
      drain();
      check("t2_hit_total", int'(hit_total), 3);

      // 6: back-to-back single-hit frames stream without a bubble
      hs_cycles.delete();
      send(5'b00001, 1'b1);
      send(5'b10000, 1'b1);
      drain();
      check("t6_records", hs_cycles.size(), 2);
      if (hs_cycles.size() == 2) check("t6_consecutive", hs_cycles[1] - hs_cycles[0], 1);

      // 3: back-pressure fills the queue; the held frame is not lost
      out_ready = 1'b0;
      send(5'b10000, 1'b1);
      send(5'b01000, 1'b1);
      send(5'b00100, 1'b1);
      send(5'b00010, 1'b1);
      send(5'b00001, 1'b1);
      in_valid = 1'b1;
      in_hit   = 5'b10001;
      in_found = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t3_in_ready_full", int'(in_ready), 0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(5'b10001, 1'b1);
      drain();

      // 4: inconsistent found flag is sticky, frame still reported
      send(5'b00000, 1'b1);
      send(5'b01100, 1'b1);
      drain();
      check("t4_err_sticky", int'(err_found), 1);

      // Randomised traffic with random back-pressure
      rand_ready = 1;
      for (int i = 0; i < 80; i++) begin
         h = NPOS'($urandom_range(0, (1 << NPOS) - 1));
         if ($urandom_range(0, 3) == 0) h = '0;
         f = (h != '0);
         if ($urandom_range(0, 15) == 0) f = !f;
         send(h, f);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end
      drain();
      rand_ready = 0;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      drain();
      check("rand_hit_total", int'(hit_total), exp_total);

      // 5: reset in the middle of a frame
      out_ready = 1'b0;
      send(5'b11111, 1'b1);
      waited = 0;
      while (!out_valid && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check("t5_frame_loaded", int'(out_valid), 1);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      out_ready  = 1'b0;
      #2;
      monitor_en = 0;
      rst_n      = 1'b0;
      #1;
      check("t5_out_valid", int'(out_valid), 0);
      check("t5_out_pos", int'(out_pos), 0);
      check("t5_out_last", int'(out_last), 0);
      check("t5_out_nomatch", int'(out_nomatch), 0);
      check("t5_hit_total", int'(hit_total), 0);
      check("t5_err_found", int'(err_found), 0);
      exp_q.delete();
      next_id   = 0;
      exp_total = 0;
      exp_err   = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n      = 1'b1;
      monitor_en = 1;
      out_ready  = 1'b1;
      send(5'b00100, 1'b1);
      drain();
      check("t5_post_total", int'(hit_total), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
